// File: rtl/mem_wb_buffer.sv
// Memory-writeback FIFO: 1-cycle enq->deq latency, enq_ready drops when full (even if a deq is in flight).
// Define MEM_WB_BUFFER_FLOW_EN to let an empty buffer pass the enq entry straight to deq in the same cycle.
module mem_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_enq_valid,
  output logic                     io_enq_ready,
  input  logic [6:0]               io_enq_bits_uop_rob_idx,
  input  logic [6:0]               io_enq_bits_uop_pdst,
  input  logic                     io_enq_bits_uop_is_amo,
  input  logic                     io_enq_bits_uop_uses_stq,
  input  logic [1:0]               io_enq_bits_uop_dst_rtype,
  input  logic [XLEN-1:0]          io_enq_bits_data,
  input  logic                     io_enq_bits_predicated,
  output logic                     io_deq_valid,
  input  logic                     io_deq_ready,
  output logic [6:0]               io_deq_bits_uop_rob_idx,
  output logic [6:0]               io_deq_bits_uop_pdst,
  output logic                     io_deq_bits_uop_is_amo,
  output logic                     io_deq_bits_uop_uses_stq,
  output logic [1:0]               io_deq_bits_uop_dst_rtype,
  output logic [XLEN-1:0]          io_deq_bits_data,
  output logic                     io_deq_bits_predicated,
  output logic                     io_rf_wen,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [6:0]      rob_idx;
    logic [6:0]      pdst;
    logic            is_amo;
    logic            uses_stq;
    logic [1:0]      dst_rtype;
    logic [XLEN-1:0] data;
    logic            predicated;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  ent_t enq_ent;
  ent_t head_ent;
  logic empty, full, flow;
  logic enq_fire, deq_vld, deq_fire, store, pop;

  always_comb begin
    enq_ent = '{rob_idx:    io_enq_bits_uop_rob_idx,
                pdst:       io_enq_bits_uop_pdst,
                is_amo:     io_enq_bits_uop_is_amo,
                uses_stq:   io_enq_bits_uop_uses_stq,
                dst_rtype:  io_enq_bits_uop_dst_rtype,
                data:       io_enq_bits_data,
                predicated: io_enq_bits_predicated};

    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    enq_fire = io_enq_valid & ~full;

`ifdef MEM_WB_BUFFER_FLOW_EN
    flow     = empty & io_enq_valid;
    deq_vld  = (~empty | io_enq_valid) & ~reset;
    head_ent = empty ? enq_ent : mem_q[rd_ptr_q];
`else
    flow     = 1'b0;
    deq_vld  = ~empty & ~reset;
    head_ent = mem_q[rd_ptr_q];
`endif

    deq_fire = deq_vld & io_deq_ready;
    // A flow-through entry consumed this cycle never touches storage
    store    = enq_fire & ~(flow & deq_fire);
    pop      = deq_fire & ~flow;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (store) begin
      mem_d[wr_ptr_q] = enq_ent;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (store && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !store) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign io_enq_ready              = ~full;
  assign io_deq_valid              = deq_vld;
  assign io_deq_bits_uop_rob_idx   = head_ent.rob_idx;
  assign io_deq_bits_uop_pdst      = head_ent.pdst;
  assign io_deq_bits_uop_is_amo    = head_ent.is_amo;
  assign io_deq_bits_uop_uses_stq  = head_ent.uses_stq;
  assign io_deq_bits_uop_dst_rtype = head_ent.dst_rtype;
  assign io_deq_bits_data          = head_ent.data;
  assign io_deq_bits_predicated    = head_ent.predicated;
  assign io_rf_wen = deq_fire & (head_ent.dst_rtype == 2'd0) & ~head_ent.predicated
                   & (head_ent.pdst != 7'd0);
  assign io_count  = count_q;

endmodule

// File: doc/mem_wb_buffer.md
MEM_WB_BUFFER -- requirements
Module: mem_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 64: width of the data field.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port io_enq_valid, input, 1 bit: upstream writeback arbiter output is valid.
REQ-006 SHALL have port io_enq_ready, output, 1 bit: buffer accepts an entry this cycle.
REQ-007 SHALL have port io_enq_bits_uop_rob_idx, input, 7 bits: ROB index.
REQ-008 SHALL have port io_enq_bits_uop_pdst, input, 7 bits: physical destination register.
REQ-009 SHALL have ports io_enq_bits_uop_is_amo and io_enq_bits_uop_uses_stq, input, 1 bit each: uop flags.
REQ-010 SHALL have port io_enq_bits_uop_dst_rtype, input, 2 bits: destination type (0 = FIX, 1 = FLT, 2 = X).
REQ-011 SHALL have port io_enq_bits_data, input, XLEN bits: load or AMO result.
REQ-012 SHALL have port io_enq_bits_predicated, input, 1 bit: result is predicated off.
REQ-013 SHALL have port io_deq_valid, output, 1 bit: head entry is valid.
REQ-014 SHALL have port io_deq_ready, input, 1 bit: downstream consumer accepts the head entry.
REQ-015 SHALL have ports io_deq_bits_*, output, one per io_enq_bits_* field with identical widths: head entry fields.
REQ-016 SHALL have port io_rf_wen, output, 1 bit: integer register file write strobe.
REQ-017 SHALL have port io_count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-018 SHALL define enq fire as io_enq_valid & io_enq_ready, and deq fire as io_deq_valid & io_deq_ready.
REQ-019 SHALL drive io_enq_ready = (count != DEPTH); a full buffer SHALL deassert ready even when a dequeue occurs in the same cycle.
REQ-020 SHALL drive io_deq_valid = (count != 0), and io_deq_bits SHALL come from the head storage entry.
REQ-021 SHALL give a one-cycle minimum latency from enq fire to io_deq_valid, with default configuration.
REQ-022 SHALL keep the enq and deq pointers as log2(DEPTH)-bit counters that wrap from DEPTH-1 to 0.
REQ-023 SHALL update count by +1 on enq-only, -1 on deq-only, and leave it unchanged on simultaneous enq and deq or on no fire.
REQ-024 SHALL preserve strict FIFO order, and the head fields SHALL stay stable while io_deq_valid is high and io_deq_ready is low.
REQ-025 SHALL drive io_rf_wen = deq fire & (dst_rtype == 0) & ~predicated & (pdst != 0), evaluated on the head entry.
REQ-026 SHALL drop writes to storage when io_enq_valid is high and the buffer is full; io_count and the existing contents SHALL remain unchanged.

Reset
REQ-027 SHALL, while reset is asserted, immediately force count, pointers, io_deq_valid, io_rf_wen and io_count to 0, and io_enq_ready to 1.
REQ-028 SHALL leave storage contents uninitialised after reset, and io_deq_bits SHALL be don't-care while io_deq_valid is 0.
REQ-029 SHALL discard all in-flight entries if reset asserts mid-operation, and no deq fire SHALL occur in that cycle.

Configuration
REQ-030 SHALL, when MEM_WB_BUFFER_FLOW_EN is defined and count == 0, raise io_deq_valid in the same cycle as io_enq_valid and present the enq fields combinationally on io_deq_bits.
REQ-031 SHALL, in that flow-through case when the entry is dequeued in the same cycle, not store it and leave count at 0.
REQ-032 SHALL, without MEM_WB_BUFFER_FLOW_EN, provide no combinational path from io_enq_* to io_deq_*, giving a minimum latency of 1 cycle.

Verification
REQ-033 SHALL cover: single enq of rob_idx=5, pdst=9, dst_rtype=0, data=0xDEAD with io_deq_ready=1 -> io_deq_valid one cycle later with matching fields, and io_rf_wen=1 for exactly one cycle.
REQ-034 SHALL cover: three back-to-back enqs with io_deq_ready=0 and DEPTH=2 -> io_enq_ready=0 after two, the third is held upstream, and io_count=2.
REQ-035 SHALL cover: a full buffer with io_deq_ready=1 and io_enq_valid=1 -> cycle 1 deq only with io_enq_ready=0, cycle 2 enq accepted, and order preserved.
REQ-036 SHALL cover: enqs with predicated=1, pdst=0, and dst_rtype=1 -> each dequeues normally with io_rf_wen=0.
REQ-037 SHALL cover: reset asserted asynchronously with io_count=2 -> io_deq_valid=0 and io_count=0 before the next clock edge, and subsequent enqs start at pointer 0.
REQ-038 SHALL cover: with MEM_WB_BUFFER_FLOW_EN, enq into an empty buffer with io_deq_ready=1 -> io_deq_valid in the same cycle and io_count stays 0.
